// File: rtl/xactor_slave.sv
// Memory-backed transactor completer; ready rises WAIT_CYCLES edges after the setup edge.
// No internal backpressure beyond wait states; sel drop aborts, en low in ACK holds the transfer.
module xactor_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        en,
  input  logic [16:0] addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        slv_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [AW-1:0]  addr_q, addr_nxt;
  logic [31:0]    wr_data_q, wr_data_nxt;
  logic           wr_en_q, wr_en_nxt;
  logic           err_q, err_nxt;
  logic [31:0]    rd_data_nxt;
  logic           ready_nxt, slv_err_nxt;
  logic           mem_we;
  logic           err_now;
  logic [31:0]    mem [DEPTH];

  // Full 17-bit compare so aliased high addresses are still flagged.
  assign err_now = (addr >= DEPTH_L);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_nxt    = addr_q;
    wr_data_nxt = wr_data_q;
    wr_en_nxt   = wr_en_q;
    err_nxt     = err_q;
    rd_data_nxt = rd_data;
    ready_nxt   = ready;
    slv_err_nxt = slv_err;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !en) begin
          addr_nxt    = addr[AW-1:0];
          wr_data_nxt = wr_data;
          wr_en_nxt   = wr_en;
          err_nxt     = err_now;
          if (WAIT_CYCLES == 0) begin
            state_nxt   = ACK;
            ready_nxt   = 1'b1;
            slv_err_nxt = err_now;
            if (!wr_en) rd_data_nxt = err_now ? 32'h0 : mem[addr[AW-1:0]];
          end else begin
            cnt_nxt   = WAIT_L;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!sel) begin
          state_nxt   = IDLE;
          ready_nxt   = 1'b0;
          slv_err_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nxt   = ACK;
            ready_nxt   = 1'b1;
            slv_err_nxt = err_q;
            if (!wr_en_q) rd_data_nxt = err_q ? 32'h0 : mem[addr_q];
          end
        end
      end
      ACK: begin
        if (!sel) begin
          state_nxt   = IDLE;
          ready_nxt   = 1'b0;
          slv_err_nxt = 1'b0;
        end else if (en) begin
          mem_we      = wr_en_q && !err_q;
          state_nxt   = IDLE;
          ready_nxt   = 1'b0;
          slv_err_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_data   <= '0;
      ready     <= 1'b0;
      slv_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr_q    <= addr_nxt;
      wr_data_q <= wr_data_nxt;
      wr_en_q   <= wr_en_nxt;
      err_q     <= err_nxt;
      rd_data   <= rd_data_nxt;
      ready     <= ready_nxt;
      slv_err   <= slv_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[addr_q] <= wr_data_q;
    end
  end

endmodule

// File: tb/tb_xactor_slave.sv
// Drives three slaves (0, 3 and 4 wait states) and checks them against a transfer-level memory model.
module tb_xactor_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel     [3];
  logic        en      [3];
  logic [16:0] addr    [3];
  logic [31:0] wr_data [3];
  logic        wr_en   [3];
  logic [31:0] rd_data [3];
  logic        ready   [3];
  logic        slv_err [3];

  logic [31:0] mem_m   [3][256];
  logic [31:0] last_rd [3];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic int wc_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    xactor_slave #(.DEPTH(256), .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 4))) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel    (sel[g]),
      .en     (en[g]),
      .addr   (addr[g]),
      .wr_data(wr_data[g]),
      .wr_en  (wr_en[g]),
      .rd_data(rd_data[g]),
      .ready  (ready[g]),
      .slv_err(slv_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      last_rd[k] = '0;
      for (int i = 0; i < 256; i++) mem_m[k][i] = '0;
    end
  endtask

  // One transfer on slave k. abort_at: access cycle index where sel drops (-1 = none).
  // hold: extra ACK cycles with en low before completing.
  task automatic xfer(input int k, input bit wr, input logic [16:0] a, input logic [31:0] d,
                      input int abort_at, input int hold);
    int w;
    bit err;
    w   = wc_of(k);
    err = (a >= 17'd256);
    @(negedge clk);
    chk($sformatf("s%0d setup_ready", k), 32'(ready[k]), 32'd0);
    sel[k] = 1'b1; en[k] = 1'b0; addr[k] = a; wr_data[k] = d; wr_en[k] = wr;
    for (int i = 0; i <= w; i++) begin
      @(negedge clk);
      chk($sformatf("s%0d ready_acc%0d a=%h", k, i, a), 32'(ready[k]), 32'(i == w));
      if (i == w) begin
        if (!wr) last_rd[k] = err ? 32'h0 : mem_m[k][a[7:0]];
        chk($sformatf("s%0d slv_err a=%h", k, a), 32'(slv_err[k]), 32'(err));
        chk($sformatf("s%0d rd_data a=%h wr=%0d", k, a, wr), rd_data[k], last_rd[k]);
      end
      if (i == abort_at) begin
        sel[k] = 1'b0; en[k] = 1'b0;
        return;
      end
      if (i == w) begin
        for (int h = 0; h < hold; h++) begin
          sel[k] = 1'b1; en[k] = 1'b0;
          @(negedge clk);
          chk($sformatf("s%0d hold_ready", k), 32'(ready[k]), 32'd1);
          chk($sformatf("s%0d hold_err", k), 32'(slv_err[k]), 32'(err));
        end
      end
      sel[k] = 1'b1; en[k] = 1'b1;
    end
    if (wr && !err) mem_m[k][a[7:0]] = d;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("s%0d idle_ready", k), 32'(ready[k]), 32'd0);
      sel[k] = 1'b0; en[k] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      sel[k] = 1'b0; en[k] = 1'b0; addr[k] = '0; wr_data[k] = '0; wr_en[k] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("s%0d rst_ready", k), 32'(ready[k]), 32'd0);
      chk($sformatf("s%0d rst_err", k), 32'(slv_err[k]), 32'd0);
      chk($sformatf("s%0d rst_rd", k), rd_data[k], 32'd0);
    end
    rst_n = 1'b1;

    // Basic write/read, then the wait-state read of a reset word.
    xfer(0, 1'b1, 17'd5, 32'hDEADBEEF, -1, 0);
    xfer(0, 1'b0, 17'd5, 32'h0, -1, 0);
    idle(0, 1);
    xfer(1, 1'b0, 17'd0, 32'h0, -1, 0);
    idle(1, 1);

    // Range edges.
    xfer(0, 1'b1, 17'd256, 32'h1234, -1, 0);
    xfer(0, 1'b0, 17'd255, 32'h0, -1, 0);
    xfer(0, 1'b0, 17'h1FFFF, 32'h0, -1, 0);
    chk("oor_write_no_alias", mem_m[0][0], 32'h0);

    // Back-to-back writes then reads with no idle cycles.
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 17'(i), 32'(i + 1), -1, 0);
    for (int i = 0; i < 4; i++) xfer(0, 1'b0, 17'(i), 32'h0, -1, 0);
    idle(0, 1);

    // Abort during wait states leaves memory untouched.
    xfer(2, 1'b1, 17'd7, 32'hAA, 1, 0);
    xfer(2, 1'b0, 17'd7, 32'h0, -1, 0);
    idle(2, 1);

    // Access without setup from IDLE is ignored.
    @(negedge clk);
    sel[1] = 1'b1; en[1] = 1'b1; addr[1] = 17'd9; wr_data[1] = 32'h5555; wr_en[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("viol_ready", 32'(ready[1]), 32'd0);
    end
    sel[1] = 1'b0; en[1] = 1'b0;
    xfer(1, 1'b0, 17'd9, 32'h0, -1, 0);
    idle(1, 1);

    // Randomized traffic with aborts, ACK holds and idle gaps.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        logic [16:0] a;
        int ab, hd;
        case ($urandom_range(0, 3))
          0: a = 17'($urandom);
          1: a = 17'($urandom_range(250, 260));
          default: a = 17'($urandom_range(0, 15));
        endcase
        ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, wc_of(k)) : -1;
        hd = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
        xfer(k, 1'($urandom), a, $urandom, ab, hd);
        if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(1, 2));
      end
      idle(k, 1);
    end

    // Reset asserted while a read sits in ACK.
    xfer(0, 1'b1, 17'd5, 32'hDEADBEEF, -1, 0);
    @(negedge clk);
    sel[0] = 1'b1; en[0] = 1'b0; addr[0] = 17'd5; wr_en[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready", 32'(ready[0]), 32'd1);
    chk("pre_rst_rd", rd_data[0], 32'hDEADBEEF);
    en[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready[0]), 32'd0);
    chk("mid_rst_err", 32'(slv_err[0]), 32'd0);
    chk("mid_rst_rd", rd_data[0], 32'd0);
    for (int k = 0; k < 3; k++) begin
      sel[k] = 1'b0; en[k] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b0, 17'd5, 32'h0, -1, 0);
    idle(0, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
